// File: rtl/tdm_demultiplexer_1to4.sv
// Framed 1-to-4 TDM demultiplexer: gathers a 4-beat serial frame and presents it in parallel.
// Optional FRAME_COUNT_EN adds an 8-bit count of delivered frames (frame_cnt).
module tdm_demultiplexer_1to4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sel,
  output logic             err_sync
`ifdef FRAME_COUNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  // state   | meaning
  // IDLE    | waiting for a start-of-frame beat (channel 0)
  // COLLECT | channels 1..3 pending, out_sel names the next one
  // HOLD    | completed frame on outputs, waiting for consumer
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shadow0, shadow1, shadow2;
  logic [WIDTH-1:0] shadow0_nxt, shadow1_nxt, shadow2_nxt;
  logic [WIDTH-1:0] out0_nxt, out1_nxt, out2_nxt, out3_nxt;
  logic             out_valid_nxt;
  logic [1:0]       out_sel_nxt;
  logic             err_sync_nxt;
  logic             accept;
  logic             handshake;

  assign in_ready  = (state != HOLD);
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow0   <= '0;
      shadow1   <= '0;
      shadow2   <= '0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out_valid <= 1'b0;
      out_sel   <= 2'd0;
      err_sync  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow0   <= shadow0_nxt;
      shadow1   <= shadow1_nxt;
      shadow2   <= shadow2_nxt;
      out0      <= out0_nxt;
      out1      <= out1_nxt;
      out2      <= out2_nxt;
      out3      <= out3_nxt;
      out_valid <= out_valid_nxt;
      out_sel   <= out_sel_nxt;
      err_sync  <= err_sync_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shadow0_nxt   = shadow0;
    shadow1_nxt   = shadow1;
    shadow2_nxt   = shadow2;
    out0_nxt      = out0;
    out1_nxt      = out1;
    out2_nxt      = out2;
    out3_nxt      = out3;
    out_valid_nxt = out_valid;
    out_sel_nxt   = out_sel;
    err_sync_nxt  = err_sync;
    case (state)
      IDLE: begin
        // beats without sof are dropped silently while hunting for a frame start
        if (accept && in_sof) begin
          shadow0_nxt = in_data;
          out_sel_nxt = 2'd1;
          state_nxt   = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (in_sof) begin
            err_sync_nxt = 1'b1;
            shadow0_nxt  = in_data;
            out_sel_nxt  = 2'd1;
          end else begin
            case (out_sel)
              2'd1: begin
                shadow1_nxt = in_data;
                out_sel_nxt = 2'd2;
              end
              2'd2: begin
                shadow2_nxt = in_data;
                out_sel_nxt = 2'd3;
              end
              default: begin
                // channel 3 bypasses the shadows straight onto the outputs
                out0_nxt      = shadow0;
                out1_nxt      = shadow1;
                out2_nxt      = shadow2;
                out3_nxt      = in_data;
                out_valid_nxt = 1'b1;
                out_sel_nxt   = 2'd0;
                state_nxt     = HOLD;
              end
            endcase
          end
        end
      end
      HOLD: begin
        if (handshake) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FRAME_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= 8'd0;
    else if (handshake)
      frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule
